// File: rtl/camera_pkg.sv
// Shared types for the OV7670 capture path: capture FSM states and the
// RGB444 layout across the two camera bytes of a pixel.
package camera_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC,
    ST_VBLANK,
    ST_ACTIVE,
    ST_SKIP
  } cap_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // R sits in the low nibble of the first byte; G/B fill the second byte.
  localparam int R_MSB = 3;
  localparam int R_LSB = 0;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  function automatic rgb444_t pack_rgb444(input logic [7:0] hi, input logic [7:0] lo);
    rgb444_t p;
    p.r = hi[R_MSB:R_LSB];
    p.g = lo[G_MSB:G_LSB];
    p.b = lo[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture into the frame BRAM, with optional 2:1 decimation
// and per-frame done/geometry-error reporting.
module ov7670_capture
  import camera_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_BITS   = 12,
  parameter int DOWNSAMPLE   = 0,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input  logic                  pclk,
  input  logic                  resend,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            d,
  input  logic                  capture_en,
  output logic [ADDR_BITS-1:0]  wraddress,
  output logic [PIXEL_BITS-1:0] wrdata,
  output logic                  wren,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [7:0]            frame_count
);

  localparam int SRC_W = (DOWNSAMPLE != 0) ? 2*IMAGE_WIDTH  : IMAGE_WIDTH;
  localparam int SRC_H = (DOWNSAMPLE != 0) ? 2*IMAGE_HEIGHT : IMAGE_HEIGHT;
  localparam int CW    = $clog2((SRC_W > SRC_H) ? SRC_W : SRC_H) + 2;

  localparam logic [CW-1:0]        SRC_W_C = CW'(SRC_W);
  localparam logic [CW-1:0]        SRC_H_C = CW'(SRC_H);
  localparam logic [CW-1:0]        DST_W_C = CW'(IMAGE_WIDTH);
  localparam logic [CW-1:0]        DST_H_C = CW'(IMAGE_HEIGHT);
  localparam logic [ADDR_BITS-1:0] LINE_A  = ADDR_BITS'(IMAGE_WIDTH);

  logic           vsync_q, href_q, href_d;
  logic [7:0]     d_q, hi_q;
  logic           phase, line_act;
  cap_state_e     state_q, state_d;
  logic           frame_start, frame_end;
  rgb444_t        pix_q;
  logic [1:0]     vld_pipe;  // [0] kept pixel assembled, [1] BRAM write
  logic [CW-1:0]  src_col, src_row, dst_col, dst_row;
  logic [ADDR_BITS-1:0] line_base, addr_ptr;
  logic           err_acc;

  logic href_rise, line_end, pix_fire, keep_now, row_kept, wr_fire;

  assign href_rise = href_q & ~href_d;
  assign line_end  = ~href_q & href_d & line_act;
  assign pix_fire  = line_act & href_q & phase;
  assign row_kept  = (DOWNSAMPLE == 0) || !src_row[0];
  assign keep_now  = (DOWNSAMPLE == 0) || (!src_col[0] && !src_row[0]);
  assign wr_fire   = vld_pipe[0] && (dst_col < DST_W_C) && (dst_row < DST_H_C);
  assign wren      = vld_pipe[1];

  always_ff @(posedge pclk) begin
    if (resend) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      href_d  <= 1'b0;
      d_q     <= '0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      href_d  <= href_q;
      d_q     <= d;
    end
  end

  always_ff @(posedge pclk) begin
    if (resend) state_q <= ST_RESYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_RESYNC: if (vsync_q) state_d = ST_VBLANK;
      ST_VBLANK: if (!vsync_q) begin
        state_d     = capture_en ? ST_ACTIVE : ST_SKIP;
        frame_start = 1'b1;
      end
      ST_ACTIVE: if (vsync_q) begin
        state_d   = ST_VBLANK;
        frame_end = 1'b1;
      end
      ST_SKIP:   if (vsync_q) state_d = ST_VBLANK;
      default:   state_d = ST_RESYNC;
    endcase
  end

  // A line is only counted if its href rise is seen while already ACTIVE.
  always_ff @(posedge pclk) begin
    if (resend) begin
      phase    <= 1'b0;
      line_act <= 1'b0;
      hi_q     <= '0;
      pix_q    <= '0;
      vld_pipe <= '0;
    end else begin
      phase    <= href_q & ~phase;
      line_act <= (state_q == ST_ACTIVE) & href_q & (line_act | href_rise);
      if (href_q && !phase) hi_q <= d_q;
      if (pix_fire) pix_q <= pack_rgb444(hi_q, d_q);
      vld_pipe <= {wr_fire, pix_fire & keep_now};
    end
  end

  always_ff @(posedge pclk) begin
    if (resend || frame_start) begin
      src_col   <= '0;
      src_row   <= '0;
      dst_col   <= '0;
      dst_row   <= '0;
      line_base <= '0;
      addr_ptr  <= '0;
      err_acc   <= 1'b0;
    end else begin
      if (href_rise) begin
        src_col <= '0;
        dst_col <= '0;
      end else begin
        if (pix_fire)    src_col <= src_col + CW'(1);
        if (vld_pipe[0]) dst_col <= dst_col + CW'(1);
      end
      if (wr_fire) addr_ptr <= addr_ptr + ADDR_BITS'(1);
      if (line_end) begin
        src_row <= src_row + CW'(1);
        err_acc <= err_acc | phase | (src_col != SRC_W_C);
        // Next line base moves by a full line even if this one was short.
        if (row_kept) begin
          dst_row   <= dst_row + CW'(1);
          line_base <= line_base + LINE_A;
          addr_ptr  <= line_base + LINE_A;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (resend) begin
      wraddress   <= '0;
      wrdata      <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      if (wr_fire) begin
        wraddress <= addr_ptr;
        wrdata    <= PIXEL_BITS'(pix_q);
      end
      frame_done <= frame_end;
      if (frame_end) begin
        frame_error <= err_acc | (src_row != SRC_H_C);
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench: camera frames are driven on one bus, expected BRAM writes
// and frame reports are queued and matched when the DUTs present them.
module tb_ov7670_capture;

  localparam int W = 8;
  localparam int H = 6;

  logic pclk = 1'b0;
  logic resend, vsync, href, capture_en, sel;
  logic [7:0] d;
  logic vs0, vs1;
  logic [5:0]  wa0, wa1;
  logic [11:0] wd0, wd1;
  logic we0, we1, fd0, fd1, fe0, fe1;
  logic [7:0] fc0, fc1;

  // Only the selected DUT sees vsync fall; the other idles in blanking.
  assign vs0 = sel ? 1'b1 : vsync;
  assign vs1 = sel ? vsync : 1'b1;

  ov7670_capture #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_BITS(12),
                   .DOWNSAMPLE(0), .ADDR_BITS(6)) dut0 (
    .pclk(pclk), .resend(resend), .vsync(vs0), .href(href), .d(d),
    .capture_en(capture_en), .wraddress(wa0), .wrdata(wd0), .wren(we0),
    .frame_done(fd0), .frame_error(fe0), .frame_count(fc0));

  ov7670_capture #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_BITS(12),
                   .DOWNSAMPLE(1), .ADDR_BITS(6)) dut1 (
    .pclk(pclk), .resend(resend), .vsync(vs1), .href(href), .d(d),
    .capture_en(capture_en), .wraddress(wa1), .wrdata(wd1), .wren(we1),
    .frame_done(fd1), .frame_error(fe1), .frame_count(fc1));

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct { int dut; int addr; int data; int cyc; } wr_t;
  typedef struct { int dut; int err;  int cnt;  int cyc; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t ew;
  dn_t ed;
  int  n_chk = 0;
  int  n_fail = 0;
  int  exp_cnt [2];
  int  salt = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: compare every write and every frame report against the queues.
  always @(negedge pclk) begin
    if (we0 === 1'b1 || we1 === 1'b1) begin
      if (wq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got dut0 %0b/%0h dut1 %0b/%0h want none (cycle %0d)",
                 we0, wa0, we1, wa1, cyc);
      end else begin
        ew = wq.pop_front();
        chk("wr_dut",  {63'd0, we1}, ew.dut);
        chk("wr_addr", we1 ? wa1 : wa0, ew.addr);
        chk("wr_data", we1 ? wd1 : wd0, ew.data);
        chk("wr_cycle", cyc, ew.cyc);
      end
    end
    if (fd0 === 1'b1 || fd1 === 1'b1) begin
      if (dq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got dut0 %0b dut1 %0b want none (cycle %0d)", fd0, fd1, cyc);
      end else begin
        ed = dq.pop_front();
        chk("done_dut",   {63'd0, fd1}, ed.dut);
        chk("done_error", fd1 ? fe1 : fe0, ed.err);
        chk("done_count", fd1 ? fc1 : fc0, ed.cnt);
        chk("done_cycle", cyc, ed.cyc);
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [11:0] pix_val(bit ds, int r, int c);
    int v;
    v = (ds ? (r*64 + c) : (r*16 + c)) + salt*256;
    return 12'(v & 'hFFF);
  endfunction

  // One camera frame; the expected writes/report are queued as bytes go out.
  task automatic frame(input int dut, input int nrows, input int ncols,
                       input int short_row, input int odd_row, input bit cap,
                       input int rs_row, input int rs_px);
    bit ds, keep, dead, killed;
    int srcw, srch, err, nc, dr, dc;
    logic [11:0] p;
    ds   = (dut == 1);
    srcw = ds ? 2*W : W;
    srch = ds ? 2*H : H;
    salt++;
    sel = ds; capture_en = cap; vsync = 1'b1; href = 1'b0;
    repeat (4) step();
    vsync = 1'b0;
    repeat (3) step();
    err  = (nrows != srch);
    dead = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      nc = (r == short_row) ? ncols - 1 : ncols;
      if (nc != srcw || r == odd_row) err = 1;
      for (int c = 0; c < nc; c++) begin
        p = pix_val(ds, r, c);
        if (r == rs_row && c == rs_px) begin
          resend = 1'b1; dead = 1'b1; exp_cnt[0] = 0; exp_cnt[1] = 0;
        end
        href = 1'b1;
        d = {~p[3:0], p[11:8]};
        step();
        resend = 1'b0;
        d = p[7:0];
        keep   = !ds || (r % 2 == 0 && c % 2 == 0);
        dr     = ds ? r / 2 : r;
        dc     = ds ? c / 2 : c;
        killed = (rs_row >= 0) && (r > rs_row || (r == rs_row && c >= rs_px - 1));
        if (cap && keep && !killed && dr < H && dc < W)
          wq.push_back('{dut, dr*W + dc, int'(p), cyc + 3});
        step();
      end
      if (r == odd_row) begin
        d = 8'h5A;
        step();
      end
      href = 1'b0; d = 8'h00;
      repeat (4) step();
      if (!cap && r == 1) capture_en = 1'b1;
    end
    repeat (2) step();
    vsync = 1'b1;
    if (cap && !dead) begin
      exp_cnt[dut] = (exp_cnt[dut] + 1) % 256;
      dq.push_back('{dut, err, exp_cnt[dut], cyc + 2});
    end
    step();
  endtask

  initial begin
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    resend = 1'b1; vsync = 1'b1; href = 1'b0; d = 8'h00; capture_en = 1'b1; sel = 1'b0;
    repeat (3) step();
    resend = 1'b0;
    step();
    @(negedge pclk);
    chk("rst_wren0", we0, 0);
    chk("rst_addr0", wa0, 0);
    chk("rst_data0", wd0, 0);
    chk("rst_done0", fd0, 0);
    chk("rst_err0",  fe0, 0);
    chk("rst_cnt0",  fc0, 0);
    chk("rst_wren1", we1, 0);
    chk("rst_cnt1",  fc1, 0);

    frame(0, H,     W, -1, -1, 1'b1, -1, 0);  // clean frame
    frame(0, H,     W,  3, -1, 1'b1, -1, 0);  // line 3 one pixel short
    frame(0, H,     W, -1,  2, 1'b1, -1, 0);  // line 2 ends on an odd byte
    frame(0, H + 4, W, -1, -1, 1'b1, -1, 0);  // too many lines
    frame(0, H,     W, -1, -1, 1'b1, -1, 0);  // clean again clears error
    frame(0, H,     W, -1, -1, 1'b0, -1, 0);  // skipped, enable flips mid-frame
    chk("skip_count0", fc0, exp_cnt[0]);
    frame(0, H,     W, -1, -1, 1'b1, -1, 0);  // re-enabled capture
    frame(1, 2*H, 2*W, -1, -1, 1'b1, -1, 0);  // decimated 16x12 source
    frame(0, H,     W, -1, -1, 1'b1,  3, 4);  // resend mid line 3
    frame(0, H,     W, -1, -1, 1'b1, -1, 0);  // recovers from address 0

    repeat (10) step();
    chk("writes_left", wq.size(), 0);
    chk("dones_left",  dq.size(), 0);
    chk("final_count0", fc0, exp_cnt[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Pixel-capture stage on the camera side of the frame buffer: samples the OV7670 parallel bus (RGB444, two bytes per pixel), assembles 12-bit pixels and writes them into the dual-port frame BRAM. The VGA-side read stage consumes the same BRAM on its own clock. Supports optional 2:1 decimation of a 640x480 source into the 320x240 buffer and reports per-frame completion and geometry errors.

## Interface
- IMAGE_WIDTH, 320, stored pixels per line
- IMAGE_HEIGHT, 240, stored lines per frame
- PIXEL_BITS, 12, stored pixel width (RGB444)
- DOWNSAMPLE, 0, 1 = source is 2*IMAGE_WIDTH x 2*IMAGE_HEIGHT, keep even columns of even lines
- ADDR_BITS, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), BRAM write address width
- pclk  in  1  camera pixel clock; the only clock
- resend  in  1  reset; synchronous, active-high
- vsync  in  1  camera vertical sync, high during vertical blanking
- href  in  1  camera line-valid
- d  in  8  camera data byte
- capture_en  in  1  sampled at frame start; 0 = skip that frame (freeze buffer)
- wraddress  out  ADDR_BITS  BRAM write address
- wrdata  out  PIXEL_BITS  BRAM write data {R,G,B}
- wren  out  1  BRAM write strobe
- frame_done  out  1  one-cycle pulse at end of every captured frame
- frame_error  out  1  geometry status of last captured frame, valid from frame_done until next frame_done
- frame_count  out  8  captured frames, wraps 255->0

## Operation
- Inputs vsync, href, d registered once (vsync_q, href_q, d_q); all logic uses registered copies.
- FSM: RESYNC -> wait vsync_q=1 -> VBLANK; VBLANK -> on vsync_q fall: capture_en=1 -> ACTIVE, else SKIP; SKIP -> on vsync_q rise -> VBLANK; ACTIVE -> on vsync_q rise -> VBLANK with frame_done.
- Byte phase: cleared while href_q=0; toggles each href_q=1 cycle. Phase 0 latches hi byte; phase 1 forms pixel {hi[3:0], d_q[7:4], d_q[3:0]}.
- Source counters src_col (pixels in current line), src_row (lines in frame). src_row increments on href_q fall.
- Pixel kept when DOWNSAMPLE=0, or src_col and src_row both even. Kept pixel written when dst_col < IMAGE_WIDTH and dst_row < IMAGE_HEIGHT; otherwise dropped, no write.
- wraddress from incrementing counter (no multiplier): advances per write; line start = dst_row*IMAGE_WIDTH, maintained by adding IMAGE_WIDTH per stored line, so short lines do not shift the next line.
- Odd byte count at href fall: partial byte discarded, line flagged short.
- frame_error=1 if any line length != expected source width (2*W if DOWNSAMPLE else W) or source line count != expected height.
- frame_count increments with each frame_done.

## Timing
- Reset: state RESYNC, wren=0, wraddress=0, wrdata=0, frame_done=0, frame_error=0, frame_count=0, counters cleared.
- resend mid-frame: write stops on the next cycle; nothing written until a full frame (vsync high then fall) is seen.
- Latency: second byte on d at edge k -> wren=1 with wraddress/wrdata valid after edge k+2, for exactly one cycle.
- Max write rate: one write per two pclk (no back-pressure; BRAM always accepts).
- frame_done/frame_error/frame_count update at edge after vsync_q rises in ACTIVE; frame_done cleared next cycle.
- vsync_q falling while href_q=1: line counted from the next href rise only.
- capture_en changes mid-frame ignored until next vsync fall.

## Structure
- camera_pkg: capture state enum, rgb444_t typedef, OV7670 byte-field constants (R in hi[3:0], G in lo[7:4], B in lo[3:0]).
- No sub-module; input register, byte pairing, counters and FSM in one module.

## Test plan
- Reset, one 320x240 frame, pixel n bytes {0x0A, 0xBC} -> 76800 writes, addr 0..76799, data 0xABC, frame_done once, frame_error=0, frame_count=1.
- DOWNSAMPLE=1, 640x480 frame, pixel value = src_col[11:0] -> 76800 writes, line 0 addr 5 data 10, frame_error=0.
- Line 3 with 319 pixels, others 320 -> addr 3*320+319 never written, line 4 starts at 1280, frame_error=1.
- Frame with 250 lines -> no writes for lines 240..249, frame_error=1; next clean frame clears frame_error.
- capture_en=0 at vsync fall -> zero writes, no frame_done, frame_count unchanged; re-enabled next frame captures normally.
- resend asserted at line 100 -> wren low next cycle, remainder of frame ignored, next full frame writes from addr 0.
